// File: rtl/seg_display_monitor_if.sv
// Bus bundle between the seven-segment scanner side and the display monitor.
// The master side drives the raw anode/segment lines and the error clear;
// the slave side (the monitor) returns the reconstructed display state.
interface seg_display_monitor_if;
   logic [3:0]  an;
   logic [7:0]  seg;
   logic        err_clr;
   logic [3:0]  digit0;
   logic [3:0]  digit1;
   logic [3:0]  digit2;
   logic [3:0]  digit3;
   logic [3:0]  blank_mask;
   logic [12:0] sec_count;
   logic        frame_valid;
   logic        err;
   logic        dead;

   modport master (
      output an, seg, err_clr,
      input  digit0, digit1, digit2, digit3, blank_mask, sec_count,
             frame_valid, err, dead
   );

   modport slave (
      input  an, seg, err_clr,
      output digit0, digit1, digit2, digit3, blank_mask, sec_count,
             frame_valid, err, dead
   );
endinterface

// File: rtl/seg_display_monitor.sv
// Receive-side monitor for a multiplexed 4-digit seven-segment bus.
// Synchronizes the active-low an/seg lines, filters ghosting with a
// stability counter, rebuilds the four digits and reports MM:SS in seconds
// once per complete scan frame. Also flags bus errors and scanner timeouts.
module seg_display_monitor #(
   parameter int unsigned STABLE_CYCLES  = 16,
   parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   seg_display_monitor_if.slave bus
);

   localparam logic [7:0]  STABLE_MAX = 8'(STABLE_CYCLES);
   localparam logic [19:0] TO_MAX     = 20'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {IDLE, COLLECT, EMIT} state_t;

   // Active-high abcdefg pattern to digit code; 4'hA blank, 4'hE undecodable.
   function automatic logic [3:0] decode(input logic [6:0] p);
      case (p)
         7'b1111110: return 4'd0;
         7'b0110000: return 4'd1;
         7'b1101101: return 4'd2;
         7'b1111001: return 4'd3;
         7'b0110011: return 4'd4;
         7'b1011011: return 4'd5;
         7'b1011111: return 4'd6;
         7'b1110000: return 4'd7;
         7'b1111111: return 4'd8;
         7'b1111011: return 4'd9;
         7'b0000000: return 4'hA;
         default:    return 4'hE;
      endcase
   endfunction

   logic [11:0] sync1, sync2, prev_word;
   logic [7:0]  stable_cnt;
   logic        capture;
   logic [3:0]  cap_an;
   logic [6:0]  cap_seg;

   logic        sel_valid, sel_multi;
   logic [1:0]  sel_idx;
   logic [3:0]  dec_val;
   logic        dig_cap, err_set;

   state_t      state, state_nxt;
   logic [3:0]  seen, seen_nxt;
   logic        emit;

   logic [3:0]  digit_q [4];
   logic [3:0]  blank_mask_q;
   logic [12:0] sec_count_q, sec_total;
   logic        all_numeric;
   logic        frame_valid_q;
   logic        err_q;
   logic [19:0] to_cnt;

   // Two-flop synchronizer on the full {an,seg} word; idle lines are all ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '1;
         sync2 <= '1;
      end else begin
         // NOTE: non-blocking assignments make sync2 take the old sync1,
         // giving two real flop stages instead of one collapsed wire.
         sync1 <= {bus.an, bus.seg};
         sync2 <= sync1;
      end
   end

   // Stability filter: one capture pulse when a word has been seen unchanged
   // for STABLE_CYCLES consecutive samples; no re-capture while it persists.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_word  <= '1;
         stable_cnt <= '0;
         capture    <= 1'b0;
         cap_an     <= '1;
         cap_seg    <= '1;
      end else begin
         prev_word <= sync2;
         capture   <= 1'b0;
         if (sync2 != prev_word) begin
            stable_cnt <= 8'd1;
         end else if (stable_cnt != STABLE_MAX) begin
            stable_cnt <= stable_cnt + 8'd1;
            if (stable_cnt == STABLE_MAX - 8'd1) begin
               capture <= 1'b1;
               cap_an  <= sync2[11:8];
               cap_seg <= sync2[7:1];
            end
         end
      end
   end

   // Classify the captured word: blank anodes, single digit, or illegal multi.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path
      // leaves a signal unassigned and infers a latch.
      sel_valid = 1'b0;
      sel_multi = 1'b0;
      sel_idx   = 2'd0;
      case (cap_an)
         4'b1110: begin sel_valid = 1'b1; sel_idx = 2'd0; end
         4'b1101: begin sel_valid = 1'b1; sel_idx = 2'd1; end
         4'b1011: begin sel_valid = 1'b1; sel_idx = 2'd2; end
         4'b0111: begin sel_valid = 1'b1; sel_idx = 2'd3; end
         4'b1111: sel_multi = 1'b0;
         default: sel_multi = 1'b1;
      endcase
      dec_val = decode(~cap_seg);
      dig_cap = capture && sel_valid;
      err_set = capture && (sel_multi || (sel_valid && dec_val == 4'hE));
   end

   // Frame FSM state and seen-mask register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         seen  <= '0;
      end else begin
         state <= state_nxt;
         seen  <= seen_nxt;
      end
   end

   // Frame FSM next state: EMIT clears seen, a full seen mask enters EMIT.
   always_comb begin
      seen_nxt  = (state == EMIT) ? 4'b0000 : seen;
      state_nxt = state;
      if (dig_cap) seen_nxt[sel_idx] = 1'b1;
      if (seen_nxt == 4'b1111)      state_nxt = EMIT;
      else if (seen_nxt != 4'b0000) state_nxt = COLLECT;
      else                          state_nxt = IDLE;
      emit = (state == EMIT);
   end

   // MM:SS to seconds from the currently held digits.
   always_comb begin
      all_numeric = (digit_q[0] <= 4'd9) && (digit_q[1] <= 4'd9) &&
                    (digit_q[2] <= 4'd9) && (digit_q[3] <= 4'd9);
      sec_total   = (13'(digit_q[3]) * 13'd10 + 13'(digit_q[2])) * 13'd60 +
                    13'(digit_q[1]) * 13'd10 + 13'(digit_q[0]);
   end

   // Digit capture and per-frame outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the digit array is only four visible output registers, so it
         // is reset like any other state rather than left as uninitialised storage.
         for (int i = 0; i < 4; i++) digit_q[i] <= 4'hA;
         blank_mask_q  <= 4'b1111;
         sec_count_q   <= '0;
         frame_valid_q <= 1'b0;
      end else begin
         frame_valid_q <= emit;
         if (dig_cap) digit_q[sel_idx] <= dec_val;
         if (emit) begin
            for (int i = 0; i < 4; i++) blank_mask_q[i] <= (digit_q[i] == 4'hA);
            if (all_numeric) sec_count_q <= sec_total;
         end
      end
   end

   // Sticky error flag; a new error outranks a simultaneous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)            err_q <= 1'b0;
      else if (err_set)      err_q <= 1'b1;
      else if (bus.err_clr)  err_q <= 1'b0;
   end

   // Scanner activity timeout, saturating at TIMEOUT_CYCLES.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                to_cnt <= '0;
      else if (dig_cap)          to_cnt <= '0;
      else if (to_cnt != TO_MAX) to_cnt <= to_cnt + 20'd1;
   end

   assign bus.digit0      = digit_q[0];
   assign bus.digit1      = digit_q[1];
   assign bus.digit2      = digit_q[2];
   assign bus.digit3      = digit_q[3];
   assign bus.blank_mask  = blank_mask_q;
   assign bus.sec_count   = sec_count_q;
   assign bus.frame_valid = frame_valid_q;
   assign bus.err         = err_q;
   assign bus.dead        = (to_cnt == TO_MAX);

endmodule

// File: tb/tb_seg_display_monitor.sv
// Directed bench for seg_display_monitor: drives scan sequences on the
// an/seg lines, queues expected frames, and compares each frame_valid pulse
// plus directed digit/err/dead checks.
module tb_seg_display_monitor;
   localparam int STABLE  = 16;
   localparam int TIMEOUT = 1000;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   seg_display_monitor_if bus();

   seg_display_monitor #(.STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TIMEOUT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct packed {
      logic [15:0] digits;   // {d3,d2,d1,d0}
      logic [3:0]  mask;
      logic [12:0] sec;
   } frame_t;

   frame_t exp_q[$];
   int checks = 0;
   int errors = 0;
   int frames = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Active-high abcdefg pattern for a decimal digit.
   function automatic logic [6:0] pat(input int d);
      case (d)
         0: return 7'b1111110;
         1: return 7'b0110000;
         2: return 7'b1101101;
         3: return 7'b1111001;
         4: return 7'b0110011;
         5: return 7'b1011011;
         6: return 7'b1011111;
         7: return 7'b1110000;
         8: return 7'b1111111;
         default: return 7'b1111011;
      endcase
   endfunction

   // Active-low seg bus value; 10 means blank (all lines high), dp off.
   function automatic logic [7:0] seg_of(input int d);
      if (d == 10) return 8'hFF;
      return {~pat(d), 1'b1};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int idx, input logic [7:0] s, input int hold);
      logic [3:0] sel;
      sel    = 4'b0001 << idx;
      bus.an  = ~sel;
      bus.seg = s;
      repeat (hold) tick();
   endtask

   task automatic scan(input int d3, input int d2, input int d1, input int d0);
      drive(0, seg_of(d0), 100);
      drive(1, seg_of(d1), 100);
      drive(2, seg_of(d2), 100);
      drive(3, seg_of(d3), 100);
   endtask

   task automatic push_frame(input logic [15:0] digits, input logic [3:0] mask,
                             input logic [12:0] sec);
      frame_t f;
      f.digits = digits;
      f.mask   = mask;
      f.sec    = sec;
      exp_q.push_back(f);
   endtask

   function automatic logic [15:0] cur_digits();
      return {bus.digit3, bus.digit2, bus.digit1, bus.digit0};
   endfunction

   // Scoreboard: each frame_valid pulse pops and compares one expected frame.
   always @(negedge clk) begin
      frame_t e;
      if (rst_n && bus.frame_valid) begin
         frames++;
         check("frame_expected", 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("frame_digits", 32'(cur_digits()), 32'(e.digits));
            check("frame_blank_mask", 32'(bus.blank_mask), 32'(e.mask));
            check("frame_sec_count", 32'(bus.sec_count), 32'(e.sec));
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int   bad;
      int   waited;
      int   frames_saved;

      bus.an      = 4'b1111;
      bus.seg     = 8'hFF;
      bus.err_clr = 1'b0;

      // Reset values.
      #2 rst_n = 1'b0;
      #1;
      check("rst_digits", 32'(cur_digits()), 32'hAAAA);
      check("rst_blank_mask", 32'(bus.blank_mask), 32'hF);
      check("rst_sec_count", 32'(bus.sec_count), 32'd0);
      check("rst_frame_valid", 32'(bus.frame_valid), 32'd0);
      check("rst_err", 32'(bus.err), 32'd0);
      check("rst_dead", 32'(bus.dead), 32'd0);
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (3) tick();

      // Scan 12:34 twice: two frames, 754 seconds.
      push_frame(16'h1234, 4'b0000, 13'd754);
      push_frame(16'h1234, 4'b0000, 13'd754);
      scan(1, 2, 3, 4);
      scan(1, 2, 3, 4);
      check("scan_1234_digits", 32'(cur_digits()), 32'h1234);
      check("scan_1234_sec", 32'(bus.sec_count), 32'd754);
      check("scan_1234_err", 32'(bus.err), 32'd0);
      check("scan_1234_frames", 32'(frames), 32'd2);

      // Glitch rejection: a 10-cycle pulse of a different pattern on digit 0.
      drive(0, seg_of(5), 40);
      check("glitch_pre_digit0", 32'(bus.digit0), 32'd5);
      bad = 0;
      bus.seg = seg_of(8);
      for (int i = 0; i < 10; i++) begin
         tick();
         if (bus.digit0 != 4'd5) bad++;
      end
      bus.seg = seg_of(5);
      for (int i = 0; i < 30; i++) begin
         tick();
         if (bus.digit0 != 4'd5) bad++;
      end
      check("glitch_digit0_changes", 32'(bad), 32'd0);

      // Held change: visible exactly after edge n+2+STABLE.
      bus.seg = seg_of(7);
      repeat (STABLE + 2) tick();
      check("capture_edge_minus1", 32'(bus.digit0), 32'd5);
      tick();
      check("capture_edge", 32'(bus.digit0), 32'd7);
      tick();

      // Blink: minutes blank, seconds 59; sec_count holds.
      push_frame(16'hAA59, 4'b1100, 13'd754);
      scan(10, 10, 5, 9);
      check("blink_mask", 32'(bus.blank_mask), 32'hC);
      check("blink_sec_hold", 32'(bus.sec_count), 32'd754);
      check("blink_err", 32'(bus.err), 32'd0);

      // Illegal multi-anode word.
      bus.an  = 4'b1100;
      bus.seg = seg_of(8);
      repeat (30) tick();
      check("multi_err", 32'(bus.err), 32'd1);
      check("multi_digits", 32'(cur_digits()), 32'hAA59);
      bus.err_clr = 1'b1;
      tick();
      bus.err_clr = 1'b0;
      check("err_clr", 32'(bus.err), 32'd0);

      // Undecodable pattern on digit 2.
      drive(2, ~8'b1000_0000, 30);
      check("undecodable_digit2", 32'(bus.digit2), 32'hE);
      check("undecodable_err", 32'(bus.err), 32'd1);
      bus.err_clr = 1'b1;
      tick();
      bus.err_clr = 1'b0;
      check("err_clr_2", 32'(bus.err), 32'd0);

      // err_clr on the same edge as a new error: error wins.
      bus.an  = 4'b1100;
      bus.seg = seg_of(8);
      repeat (STABLE + 2) tick();
      check("collision_pre_err", 32'(bus.err), 32'd0);
      bus.err_clr = 1'b1;
      tick();
      bus.err_clr = 1'b0;
      check("collision_err", 32'(bus.err), 32'd1);
      repeat (10) tick();
      check("collision_digits", 32'(cur_digits()), 32'hAE59);

      // Frame containing 4'hE: counts toward seen, blocks sec_count load.
      push_frame(16'h0E00, 4'b0000, 13'd754);
      drive(0, seg_of(0), 100);
      drive(1, seg_of(0), 100);
      drive(3, seg_of(0), 100);
      check("e_frame_sec_hold", 32'(bus.sec_count), 32'd754);

      // Timeout: last capture was STABLE+2 edges into the 100-cycle digit 3 hold.
      check("dead_before_idle", 32'(bus.dead), 32'd0);
      bus.an  = 4'b1111;
      bus.seg = 8'hFF;
      waited  = 0;
      while (!bus.dead && waited < 1100) begin
         tick();
         waited++;
      end
      check("dead_latency", 32'(waited), 32'(TIMEOUT - (100 - (STABLE + 2)) + 1));

      // Resume with 99:59; dead drops the cycle after the first capture.
      push_frame(16'h9959, 4'b0000, 13'd5999);
      bus.an  = 4'b1110;
      bus.seg = seg_of(9);
      repeat (STABLE + 2) tick();
      check("dead_before_capture", 32'(bus.dead), 32'd1);
      tick();
      check("dead_after_capture", 32'(bus.dead), 32'd0);
      repeat (100 - (STABLE + 3)) tick();
      drive(1, seg_of(5), 100);
      drive(2, seg_of(9), 100);
      drive(3, seg_of(9), 100);
      check("max_sec", 32'(bus.sec_count), 32'd5999);

      // Reset mid-frame after two captures.
      drive(0, seg_of(1), 100);
      drive(1, seg_of(2), 100);
      bus.an  = 4'b1011;
      bus.seg = seg_of(3);
      repeat (30) tick();
      #1 rst_n = 1'b0;
      #1;
      check("midrst_digits", 32'(cur_digits()), 32'hAAAA);
      check("midrst_blank_mask", 32'(bus.blank_mask), 32'hF);
      check("midrst_sec_count", 32'(bus.sec_count), 32'd0);
      check("midrst_err", 32'(bus.err), 32'd0);
      check("midrst_dead", 32'(bus.dead), 32'd0);
      repeat (3) tick();
      rst_n = 1'b1;
      frames_saved = frames;
      drive(2, seg_of(3), 100);
      drive(3, seg_of(4), 100);
      check("midrst_no_early_frame", 32'(frames), 32'(frames_saved));
      push_frame(16'h4365, 4'b0000, 13'd2645);
      drive(0, seg_of(5), 100);
      drive(1, seg_of(6), 100);
      check("midrst_frame_count", 32'(frames), 32'(frames_saved + 1));
      check("midrst_sec", 32'(bus.sec_count), 32'd2645);

      repeat (5) tick();
      check("frames_pending", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
